dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter sharing the single data-memory port between the CPU (master 0) and a program/data loader (master 1).
- Performs the byte-address to word-index mapping: index = (addr - ADDR_BASE) >> 2, 11 bits.
- Enforces round-robin fairness with a bounded hold count, and flags misaligned or out-of-range accesses without touching memory.
- Sits between the cpu/loader and dmem in the top-level computer.

Parameters:
- ADDR_BASE, 32'h10010000, byte address mapped to word index 0.
- IDX_W, 11, word-index width; memory depth = 2^IDX_W words.
- MAX_HOLD, 8, maximum consecutive grants to one master while the other master is requesting.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 access request; held with addr/we/wdata until m0_gnt.
- m0_we  input  1  1 = write, 0 = read.
- m0_addr  input  32  byte address.
- m0_wdata  input  32  write data.
- m0_gnt  output  1  access performed this cycle.
- m0_rdata  output  32  read data, valid when m0_gnt=1 and m0_we=0.
- m0_err  output  1  with m0_gnt: access rejected.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_err: same as m0_*, for master 1.
- dm_r  output  1  dmem read strobe.
- dm_w  output  1  dmem write strobe; write commits on posedge.
- dm_addr  output  IDX_W  word index.
- dm_wdata  output  32  write data to dmem.
- dm_rdata  input  32  dmem asynchronous read data.

Behaviour:
- State register: st in {IDLE, OWN0, OWN1}. Also last (last owner, 1 bit) and hold (4-bit grant counter).
- Reset (synchronous): st=IDLE, last=1 (master 0 wins first tie), hold=0.
  - While reset=1, all outputs are forced to 0 combinationally, so no dmem write can occur in a reset cycle, even mid-burst.
- IDLE: no gnt, dm_r=dm_w=0.
  - Next state: if exactly one req, own that master. If both req, own !last.
- OWNx with mx_req=1: mx_gnt=1 in the same cycle (combinational).
  - dm_addr, dm_wdata, dm_r=~we, dm_w=we are driven from master x.
  - mx_rdata = dm_rdata; the other master's rdata = 0.
  - Latency: one idle cycle from request in IDLE to first grant; back-to-back grants each cycle thereafter.
- Grant counting: each grant increments hold, saturating at MAX_HOLD.
- Switching, evaluated at each posedge in OWNx:
  - Other master requesting and (mx_req=0 or hold reaches MAX_HOLD this grant): go to OWN(other), hold=0, last=x.
  - Else if mx_req=0: go to IDLE, hold=0, last=x.
  - Else stay in OWNx.
  - Net effect: at most MAX_HOLD consecutive grants while the other master waits. Switch costs no bubble cycle.
- OWNx with mx_req=0 (owner dropped its request): no grant this cycle; switching rules apply.
- Mapping and checks, per granted access:
  - off = addr - ADDR_BASE (32-bit wrap); dm_addr = off[IDX_W+1:2].
  - err = (addr[1:0] != 0) OR (addr < ADDR_BASE) OR (off >= 4*2^IDX_W).
  - On err: gnt=1, err=1, dm_r=dm_w=0, rdata=0. The access counts toward hold.
  - Last valid word: ADDR_BASE + 4*(2^IDX_W - 1) = 32'h10011FFC (defaults).
- Masters must hold req/we/addr/wdata stable until gnt. Dropping req before gnt is legal and just withdraws the request.
- gnt is never asserted to both masters in one cycle. err is 0 whenever gnt is 0.

Test Plan:
- Reset, then m0 write 32'hDEADBEEF to 32'h10010008 -> gnt on the 2nd cycle, dm_addr=2, dm_w=1. Read back next grant -> m0_rdata=32'hDEADBEEF.
- Both req asserted from IDLE right after reset -> m0 granted first. Both held continuously -> grants follow m0 x8, m1 x8, m0 x8, with no gap cycles.
- m1 burst alone 3 words from 32'h10010000 -> dm_addr 0,1,2 on consecutive cycles. m1 drops req -> IDLE next cycle.
- Error cases -> gnt=1, err=1, dm_w=0, memory unchanged:
  - m0 write to 32'h10012000 (one past end);
  - 32'h1000FFFC (below base);
  - 32'h10010002 (misaligned).
  - 32'h10011FFC -> accepted, dm_addr=11'h7FF.
- Reset asserted during an OWN1 write burst -> dm_w=0 in the reset cycle. Next cycle st=IDLE. Simultaneous requests then -> m0 granted.
- m0 withdraws req before grant while m1 owns; m1 continues -> no m0_gnt, m1 never preempted; hold restarts only when a switch occurs.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory port.
// It maps byte addresses to word indices and rejects misaligned or out-of-range accesses.
module dmem_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h10010000,
  parameter int          IDX_W     = 11,
  parameter int          MAX_HOLD  = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,
  output logic             dm_r,
  output logic             dm_w,
  output logic [IDX_W-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [32:0] SPAN     = 33'd4 << IDX_W;
  localparam logic [3:0]  HOLD_MAX = 4'(MAX_HOLD);

  state_t      st_q, st_d;
  logic        last_q, last_d;
  logic [3:0]  hold_q, hold_d;

  logic        sel_s;
  logic        own_s;
  logic        cur_req_s;
  logic        cur_we_s;
  logic [31:0] cur_addr_s;
  logic [31:0] cur_wdata_s;
  logic        oth_req_s;
  logic [31:0] off_s;
  logic        err_s;
  logic        grant_s;
  logic        ok_s;
  logic [3:0]  hold_inc_s;

  // Owner mux, address mapping and access checks
  always_comb begin
    sel_s       = (st_q == OWN1);
    own_s       = (st_q == OWN0) || (st_q == OWN1);
    cur_req_s   = sel_s ? m1_req   : m0_req;
    cur_we_s    = sel_s ? m1_we    : m0_we;
    cur_addr_s  = sel_s ? m1_addr  : m0_addr;
    cur_wdata_s = sel_s ? m1_wdata : m0_wdata;
    oth_req_s   = sel_s ? m0_req   : m1_req;
    off_s       = cur_addr_s - ADDR_BASE;
    err_s       = (cur_addr_s[1:0] != 2'b00) || (cur_addr_s < ADDR_BASE) ||
                  ({1'b0, off_s} >= SPAN);
    grant_s     = own_s && cur_req_s && !reset;
    ok_s        = grant_s && !err_s;
    if (hold_q >= HOLD_MAX) begin
      hold_inc_s = HOLD_MAX;
    end else begin
      hold_inc_s = hold_q + 4'd1;
    end
  end

  // Drive both masters and the memory port; everything is zero while in reset
  always_comb begin
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    m0_err   = 1'b0;
    m1_err   = 1'b0;
    m0_rdata = 32'd0;
    m1_rdata = 32'd0;
    dm_r     = 1'b0;
    dm_w     = 1'b0;
    dm_addr  = '0;
    dm_wdata = 32'd0;
    if (grant_s) begin
      m0_gnt = !sel_s;
      m1_gnt = sel_s;
      m0_err = !sel_s && err_s;
      m1_err = sel_s && err_s;
    end else begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
    if (ok_s) begin
      dm_r     = !cur_we_s;
      dm_w     = cur_we_s;
      dm_addr  = off_s[IDX_W+1:2];
      dm_wdata = cur_wdata_s;
      m0_rdata = sel_s ? 32'd0 : dm_rdata;
      m1_rdata = sel_s ? dm_rdata : 32'd0;
    end else begin
      dm_r = 1'b0;
      dm_w = 1'b0;
    end
  end

  // Next-state: round-robin ownership with bounded hold while the other master waits
  always_comb begin
    st_d   = st_q;
    last_d = last_q;
    hold_d = hold_q;
    case (st_q)
      IDLE: begin
        hold_d = 4'd0;
        if (m0_req && m1_req) begin
          st_d = last_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          st_d = OWN0;
        end else if (m1_req) begin
          st_d = OWN1;
        end else begin
          st_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (oth_req_s && (!cur_req_s || (hold_inc_s >= HOLD_MAX))) begin
          st_d   = sel_s ? OWN0 : OWN1;
          hold_d = 4'd0;
          last_d = sel_s;
        end else if (!cur_req_s) begin
          st_d   = IDLE;
          hold_d = 4'd0;
          last_d = sel_s;
        end else begin
          hold_d = hold_inc_s;
        end
      end
      default: begin
        st_d   = IDLE;
        hold_d = 4'd0;
        last_d = 1'b1;
      end
    endcase
  end

  // State registers; master 0 wins the first tie after reset
  always_ff @(posedge clk_in) begin
    if (reset) begin
      st_q   <= IDLE;
      last_q <= 1'b1;
      hold_q <= 4'd0;
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants, a negedge monitor checks them.
module tb_dmem_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        dm_r, dm_w;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  logic [31:0] mem [0:2047];

  typedef struct {
    logic        m;
    logic        we;
    logic        err;
    logic [10:0] idx;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_arbiter dut (
    .clk_in(clk_in), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Data memory stand-in: asynchronous read, write on posedge
  always @(posedge clk_in) begin
    if (dm_w) mem[dm_addr] <= dm_wdata;
  end
  assign dm_rdata = mem[dm_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic m, input logic we, input logic err,
                      input logic [10:0] idx, input logic [31:0] rdata);
    exp_t e;
    e.m = m; e.we = we; e.err = err; e.idx = idx; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: every grant is matched against the oldest expectation
  always @(negedge clk_in) begin
    exp_t e;
    logic [31:0] g_rdata, o_rdata;
    logic        g_err;
    if (m0_gnt && m1_gnt) begin
      chk("dual_gnt", 32'd1, 32'd0);
    end else if (m0_gnt || m1_gnt) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", {31'd0, m1_gnt}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        g_rdata = m1_gnt ? m1_rdata : m0_rdata;
        o_rdata = m1_gnt ? m0_rdata : m1_rdata;
        g_err   = m1_gnt ? m1_err : m0_err;
        chk("gnt_master", {31'd0, m1_gnt}, {31'd0, e.m});
        chk("gnt_err", {31'd0, g_err}, {31'd0, e.err});
        chk("dm_w", {31'd0, dm_w}, {31'd0, !e.err && e.we});
        chk("dm_r", {31'd0, dm_r}, {31'd0, !e.err && !e.we});
        chk("other_rdata", o_rdata, 32'd0);
        if (!e.err) chk("dm_addr", {21'd0, dm_addr}, {21'd0, e.idx});
        if (e.err) chk("err_rdata", g_rdata, 32'd0);
        else if (!e.we) chk("rdata", g_rdata, e.rdata);
      end
    end else begin
      chk("idle_outputs", {28'd0, m0_err, m1_err, dm_w, dm_r}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic wait_gnt(input logic m, input string name, output int cyc);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      cyc++;
      if (m ? m1_gnt : m0_gnt) return;
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic m0_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic err, input logic [10:0] idx, input logic [31:0] rd);
    int c;
    push(1'b0, we, err, idx, rd);
    set_m0(1'b1, we, a, d);
    wait_gnt(1'b0, "m0_access", c);
    tick();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc, grants, cnt, guard;
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    reset = 1'b1;
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick(); tick();
    chk("reset_st", 32'(dut.st_q), 32'd0);
    chk("reset_last", {31'd0, dut.last_q}, 32'd1);
    chk("reset_hold", {28'd0, dut.hold_q}, 32'd0);
    reset = 1'b0;

    // Write, first-grant latency, read back
    push(1'b0, 1'b1, 1'b0, 11'd2, 32'd0);
    set_m0(1'b1, 1'b1, 32'h10010008, 32'hDEADBEEF);
    wait_gnt(1'b0, "first", cyc);
    chk("first_latency", 32'(cyc), 32'd2);
    tick();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    m0_access(1'b0, 32'h10010008, 32'd0, 1'b0, 11'd2, 32'hDEADBEEF);

    // Boundary and error accesses
    m0_access(1'b1, 32'h10011FFC, 32'hCAFEF00D, 1'b0, 11'h7FF, 32'd0);
    m0_access(1'b1, 32'h10012000, 32'h11111111, 1'b1, 11'd0, 32'd0);
    m0_access(1'b1, 32'h1000FFFC, 32'h22222222, 1'b1, 11'd0, 32'd0);
    m0_access(1'b1, 32'h10010002, 32'h33333333, 1'b1, 11'd0, 32'd0);
    m0_access(1'b0, 32'h10011FFC, 32'd0, 1'b0, 11'h7FF, 32'hCAFEF00D);
    m0_access(1'b0, 32'h10010000, 32'd0, 1'b0, 11'd0, 32'd0);
    tick();

    // Fairness: both requesting continuously after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) push(1'b0, 1'b0, 1'b0, 11'd2, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) push(1'b1, 1'b0, 1'b0, 11'h7FF, 32'hCAFEF00D);
    for (int i = 0; i < 8; i++) push(1'b0, 1'b0, 1'b0, 11'd2, 32'hDEADBEEF);
    set_m0(1'b1, 1'b0, 32'h10010008, 32'd0);
    set_m1(1'b1, 1'b0, 32'h10011FFC, 32'd0);
    grants = 0;
    cyc = 0;
    while (grants < 24 && cyc < 60) begin
      @(negedge clk_in);
      cyc++;
      if (m0_gnt || m1_gnt) grants++;
    end
    chk("fair_cycles", 32'(cyc), 32'd25);
    tick();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick();

    // m1 burst of three writes
    push(1'b1, 1'b1, 1'b0, 11'd0, 32'd0);
    push(1'b1, 1'b1, 1'b0, 11'd1, 32'd0);
    push(1'b1, 1'b1, 1'b0, 11'd2, 32'd0);
    set_m1(1'b1, 1'b1, 32'h10010000, 32'hA0A0A0A0);
    wait_gnt(1'b1, "burst0", cyc);
    tick();
    set_m1(1'b1, 1'b1, 32'h10010004, 32'hA1A1A1A1);
    wait_gnt(1'b1, "burst1", cyc);
    chk("burst_b2b_1", 32'(cyc), 32'd1);
    tick();
    set_m1(1'b1, 1'b1, 32'h10010008, 32'hA2A2A2A2);
    wait_gnt(1'b1, "burst2", cyc);
    chk("burst_b2b_2", 32'(cyc), 32'd1);
    tick();
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("burst_idle_st", 32'(dut.st_q), 32'd0);
    tick();

    // Reset in the middle of an m1 write burst
    push(1'b1, 1'b1, 1'b0, 11'd4, 32'd0);
    set_m1(1'b1, 1'b1, 32'h10010010, 32'hB0B0B0B0);
    wait_gnt(1'b1, "rst_burst", cyc);
    tick();
    set_m1(1'b1, 1'b1, 32'h10010014, 32'hB1B1B1B1);
    reset = 1'b1;
    @(negedge clk_in);
    chk("reset_dm_w", {31'd0, dm_w}, 32'd0);
    chk("reset_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    tick();
    reset = 1'b0;
    chk("post_reset_st", 32'(dut.st_q), 32'd0);
    push(1'b0, 1'b0, 1'b0, 11'd0, 32'hA0A0A0A0);
    push(1'b1, 1'b0, 1'b0, 11'd5, 32'd0);
    set_m0(1'b1, 1'b0, 32'h10010000, 32'd0);
    set_m1(1'b1, 1'b0, 32'h10010014, 32'd0);
    wait_gnt(1'b0, "post_reset_m0", cyc);
    tick();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    wait_gnt(1'b1, "post_reset_m1", cyc);
    tick();
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick();

    // m0 withdraws while m1 owns; after m1 saturates, m0 is served next
    for (int i = 0; i < 13; i++) push(1'b1, 1'b0, 1'b0, 11'd0, 32'hA0A0A0A0);
    push(1'b0, 1'b0, 1'b0, 11'd2, 32'hA2A2A2A2);
    set_m1(1'b1, 1'b0, 32'h10010000, 32'd0);
    cnt = 0;
    guard = 0;
    while (cnt < 12 && guard < 60) begin
      @(negedge clk_in);
      guard++;
      if (m1_gnt) begin
        cnt++;
        if (cnt == 2) begin
          tick();
          set_m0(1'b1, 1'b0, 32'h10010008, 32'd0);
        end else if (cnt == 4) begin
          tick();
          set_m0(1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
    end
    chk("withdraw_m1_grants", 32'(cnt), 32'd12);
    tick();
    set_m0(1'b1, 1'b0, 32'h10010008, 32'd0);
    wait_gnt(1'b0, "sat_switch", cyc);
    chk("sat_switch_latency", 32'(cyc), 32'd2);
    tick();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick(); tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
